alu_seq_ctrl: RTL and testbench

Multi-cycle sequencer for the processor's arithmetic unit. It sits between the instruction decoder and the register-file write port. It accepts one decoded arithmetic operation at a time: ADD and PASS finish in a single pass, MUL uses iterative shift-add, and DIV uses iterative restoring division. It holds the front end off while an operation is in flight, then issues a one-cycle result/write-enable/flag-update pulse.

---
 rtl/alu_seq_ctrl.sv | 195 +++++++++++++++++++
 tb/tb_alu_seq_ctrl.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_seq_ctrl.sv
// Multi-cycle ALU sequencer: single-pass ADD/PASS, shift-add MUL, restoring DIV.
// Optional ALU_SEQ_DIVZERO_TRAP_EN: DIV by zero completes in one cycle and raises div_zero.
module alu_seq_ctrl #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    output logic             in_ready,
    input  logic [1:0]       alu_control,
    input  logic             flag_update,
    input  logic             reg_write_in,
    input  logic [3:0]       rd_in,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    output logic [WIDTH-1:0] result,
    output logic [3:0]       rd_out,
    output logic             result_valid,
    output logic             reg_write_out,
    output logic [3:0]       flags,
    output logic             flag_we,
    output logic             busy,
    output logic             div_zero
);
    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_DONE} state_t;

    state_t             state_q;
    logic [CW-1:0]      cnt_q;
    logic [WIDTH-1:0]   a_q, b_q;
    logic [2*WIDTH-1:0] work_q;
    logic [3:0]         rd_q;
    logic               rw_q, fu_q;

    logic [WIDTH-1:0]   result_q;
    logic [3:0]         flags_q, rd_out_q;
    logic               rv_q, rwo_q, fwe_q, dz_q;

    logic               accept, dz_trap;
    logic               fin_d, c_d, v_d, rw_d, fu_d, dz_d;
    logic [WIDTH-1:0]   res_d;
    logic [3:0]         rd_d;

    `ifdef ALU_SEQ_DIVZERO_TRAP_EN
    assign dz_trap = (op_b == '0);
    `else
    assign dz_trap = 1'b0;
    `endif

    assign in_ready = (state_q == S_IDLE) || (state_q == S_DONE);
    assign busy     = (state_q == S_MUL) || (state_q == S_DIV);
    assign accept   = start && in_ready;

    // MUL: work_q = {partial product, remaining multiplier bits}, shifted right each step
    logic [WIDTH:0]     mul_sum;
    logic [2*WIDTH-1:0] mul_next;
    assign mul_sum  = {1'b0, work_q[2*WIDTH-1:WIDTH]} + (work_q[0] ? {1'b0, a_q} : '0);
    assign mul_next = {mul_sum, work_q[WIDTH-1:1]};

    // DIV: work_q = {partial remainder, dividend/quotient}, shifted left each step
    logic [WIDTH:0]     div_rsh, div_trial;
    logic               div_ge;
    logic [2*WIDTH-1:0] div_next;
    assign div_rsh   = {work_q[2*WIDTH-1:WIDTH], work_q[WIDTH-1]};
    assign div_trial = div_rsh - {1'b0, b_q};
    assign div_ge    = ~div_trial[WIDTH];
    assign div_next  = {div_ge ? div_trial[WIDTH-1:0] : div_rsh[WIDTH-1:0],
                        work_q[WIDTH-2:0], div_ge};

    logic [WIDTH:0] add_sum;
    assign add_sum = {1'b0, op_a} + {1'b0, op_b};

    function automatic logic [3:0] nzcv(input logic [WIDTH-1:0] r, input logic c, input logic v);
        return {r[WIDTH-1], (r == '0), c, v};
    endfunction

    // Completion decode: which operation finishes on this edge and with what.
    always_comb begin
        fin_d = 1'b0;
        res_d = '0;
        c_d   = 1'b0;
        v_d   = 1'b0;
        rd_d  = rd_q;
        rw_d  = rw_q;
        fu_d  = fu_q;
        dz_d  = 1'b0;
        case (state_q)
            S_MUL: if (cnt_q == '0) begin
                fin_d = 1'b1;
                res_d = mul_next[WIDTH-1:0];
                c_d   = |mul_next[2*WIDTH-1:WIDTH];
                v_d   = c_d;
            end
            S_DIV: if (cnt_q == '0) begin
                fin_d = 1'b1;
                res_d = div_next[WIDTH-1:0];
            end
            default: if (accept) begin
                rd_d = rd_in;
                rw_d = reg_write_in;
                fu_d = flag_update;
                case (alu_control)
                    2'b00: begin
                        fin_d = 1'b1;
                        res_d = add_sum[WIDTH-1:0];
                        c_d   = add_sum[WIDTH];
                        v_d   = (op_a[WIDTH-1] == op_b[WIDTH-1]) &&
                                (add_sum[WIDTH-1] != op_a[WIDTH-1]);
                    end
                    2'b11: begin
                        fin_d = 1'b1;
                        res_d = op_b;
                    end
                    2'b10: if (dz_trap) begin
                        fin_d = 1'b1;
                        res_d = '1;
                        dz_d  = 1'b1;
                        rw_d  = 1'b0;
                    end
                    default: ;
                endcase
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            a_q      <= '0;
            b_q      <= '0;
            work_q   <= '0;
            rd_q     <= '0;
            rw_q     <= 1'b0;
            fu_q     <= 1'b0;
            result_q <= '0;
            flags_q  <= '0;
            rd_out_q <= '0;
            rv_q     <= 1'b0;
            rwo_q    <= 1'b0;
            fwe_q    <= 1'b0;
            dz_q     <= 1'b0;
        end else begin
            rv_q  <= fin_d;
            rwo_q <= fin_d & rw_d;
            fwe_q <= fin_d & fu_d;
            if (fin_d) begin
                result_q <= res_d;
                flags_q  <= nzcv(res_d, c_d, v_d);
                rd_out_q <= rd_d;
                dz_q     <= dz_d;
            end
            case (state_q)
                S_MUL, S_DIV: begin
                    work_q <= (state_q == S_MUL) ? mul_next : div_next;
                    if (cnt_q == '0) state_q <= S_DONE;
                    else             cnt_q   <= cnt_q - 1'b1;
                end
                default: if (accept) begin
                    a_q  <= op_a;
                    b_q  <= op_b;
                    rd_q <= rd_in;
                    rw_q <= reg_write_in;
                    fu_q <= flag_update;
                    case (alu_control)
                        2'b01: begin
                            state_q <= S_MUL;
                            cnt_q   <= CW'(WIDTH - 1);
                            work_q  <= {{WIDTH{1'b0}}, op_b};
                        end
                        2'b10: if (dz_trap) begin
                            state_q <= S_DONE;
                        end else begin
                            state_q <= S_DIV;
                            cnt_q   <= CW'(WIDTH - 1);
                            work_q  <= {{WIDTH{1'b0}}, op_a};
                        end
                        default: state_q <= S_DONE;
                    endcase
                end else begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign result        = result_q;
    assign flags         = flags_q;
    assign rd_out        = rd_out_q;
    assign result_valid  = rv_q;
    assign reg_write_out = rwo_q;
    assign flag_we       = fwe_q;
    assign div_zero      = dz_q;
endmodule

// File: tb/tb_alu_seq_ctrl.sv
// Directed bench for alu_seq_ctrl (WIDTH=16): monitor-side model feeds a scoreboard queue.
module tb_alu_seq_ctrl;
    localparam int W = 16;

    logic          clk = 1'b0, rst_n = 1'b0, start = 1'b0;
    logic [1:0]    alu_control = 2'b00;
    logic          flag_update = 1'b0, reg_write_in = 1'b0;
    logic [3:0]    rd_in = 4'h0;
    logic [W-1:0]  op_a = '0, op_b = '0;
    logic          in_ready, result_valid, reg_write_out, flag_we, busy, div_zero;
    logic [W-1:0]  result;
    logic [3:0]    rd_out, flags;

    alu_seq_ctrl #(.WIDTH(W)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .in_ready(in_ready),
        .alu_control(alu_control), .flag_update(flag_update), .reg_write_in(reg_write_in),
        .rd_in(rd_in), .op_a(op_a), .op_b(op_b), .result(result), .rd_out(rd_out),
        .result_valid(result_valid), .reg_write_out(reg_write_out), .flags(flags),
        .flag_we(flag_we), .busy(busy), .div_zero(div_zero)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] res;
        logic [3:0]  flags;
        logic [3:0]  rd;
        logic        rwo, fwe, dz;
        int          lat, busyc, acc;
    } exp_t;

    exp_t q[$];
    exp_t mon_e;
    int   n_chk = 0, n_fail = 0, cyc = 0, busy_cnt = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic exp_t model(input logic [1:0] op, input logic [15:0] a, input logic [15:0] b,
                                   input logic [3:0] rd, input logic fu, input logic rw);
        exp_t e;
        logic [16:0] s;
        logic [31:0] p;
        logic c, v;
        c = 1'b0; v = 1'b0;
        e.rd = rd; e.rwo = rw; e.fwe = fu; e.dz = 1'b0;
        e.lat = 1; e.busyc = 0; e.acc = 0; e.res = '0;
        case (op)
            2'b00: begin
                s = {1'b0, a} + {1'b0, b};
                e.res = s[15:0];
                c = s[16];
                v = (a[15] == b[15]) && (e.res[15] != a[15]);
            end
            2'b01: begin
                p = {16'h0, a} * {16'h0, b};
                e.res = p[15:0];
                c = (p[31:16] != 16'h0);
                v = c;
                e.lat = 17; e.busyc = 16;
            end
            2'b10: begin
                if (b == 16'h0) begin
                    e.res = 16'hFFFF;
`ifdef ALU_SEQ_DIVZERO_TRAP_EN
                    e.dz = 1'b1; e.rwo = 1'b0;
`else
                    e.lat = 17; e.busyc = 16;
`endif
                end else begin
                    e.res = a / b;
                    e.lat = 17; e.busyc = 16;
                end
            end
            default: e.res = b;
        endcase
        e.flags = {e.res[15], (e.res == 16'h0), c, v};
        return e;
    endfunction

    always @(posedge clk) cyc <= cyc + 1;

    // Result check runs before accept capture so a DONE-cycle accept is scored correctly.
    always @(negedge clk) begin
        if (rst_n) begin
            if (busy) begin
                busy_cnt++;
                chk("ready_while_busy", in_ready, 0);
            end
            if (result_valid) begin
                if (q.size() == 0) begin
                    chk("spurious_result_valid", result_valid, 0);
                end else begin
                    mon_e = q.pop_front();
                    chk("result", result, mon_e.res);
                    chk("flags", flags, mon_e.flags);
                    chk("rd_out", rd_out, mon_e.rd);
                    chk("reg_write_out", reg_write_out, mon_e.rwo);
                    chk("flag_we", flag_we, mon_e.fwe);
                    chk("div_zero", div_zero, mon_e.dz);
                    chk("latency", cyc - mon_e.acc, mon_e.lat);
                    chk("busy_cycles", busy_cnt, mon_e.busyc);
                end
            end
            if (start && in_ready) begin
                mon_e = model(alu_control, op_a, op_b, rd_in, flag_update, reg_write_in);
                mon_e.acc = cyc;
                q.push_back(mon_e);
                busy_cnt = 0;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_op(input logic [1:0] op, input logic [15:0] a, input logic [15:0] b,
                          input logic [3:0] rd, input logic fu, input logic rw);
        alu_control = op; op_a = a; op_b = b; rd_in = rd; flag_update = fu; reg_write_in = rw;
    endtask

    task automatic issue(input logic [1:0] op, input logic [15:0] a, input logic [15:0] b,
                         input logic [3:0] rd, input logic fu, input logic rw);
        set_op(op, a, b, rd, fu, rw);
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_done();
        int g = 0;
        while (q.size() != 0 && g < 100) begin
            tick();
            g++;
        end
        chk("drain_timeout", q.size(), 0);
    endtask

    task automatic check_cleared(input string pfx);
        chk({pfx, "_result"}, result, 0);
        chk({pfx, "_flags"}, flags, 0);
        chk({pfx, "_rd_out"}, rd_out, 0);
        chk({pfx, "_result_valid"}, result_valid, 0);
        chk({pfx, "_reg_write_out"}, reg_write_out, 0);
        chk({pfx, "_flag_we"}, flag_we, 0);
        chk({pfx, "_busy"}, busy, 0);
        chk({pfx, "_div_zero"}, div_zero, 0);
        chk({pfx, "_in_ready"}, in_ready, 1);
    endtask

    initial begin
        int g;
        #1;
        check_cleared("reset");
        @(posedge clk);
        @(posedge clk);
        #3 rst_n = 1'b1;
        tick();

        issue(2'b00, 16'h7FFF, 16'h0001, 4'd1, 1'b1, 1'b1);
        wait_done();
        chk("add_ovf_result", result, 16'h8000);
        chk("add_ovf_flags", flags, 4'b1001);

        issue(2'b00, 16'hFFFF, 16'h0001, 4'd2, 1'b1, 1'b1);
        wait_done();
        chk("add_carry_result", result, 16'h0000);
        chk("add_carry_flags", flags, 4'b0110);

        issue(2'b01, 16'd300, 16'd300, 4'd5, 1'b1, 1'b1);
        wait_done();
        chk("mul_big_result", result, 16'h5F90);
        chk("mul_big_flags", flags, 4'b0011);
        chk("mul_big_rd", rd_out, 5);

        issue(2'b01, 16'd12, 16'd11, 4'd6, 1'b1, 1'b1);
        wait_done();
        chk("mul_small_result", result, 16'h0084);
        chk("mul_small_flags", flags, 4'b0000);

        issue(2'b10, 16'd100, 16'd7, 4'd7, 1'b1, 1'b1);
        wait_done();
        chk("div_result", result, 16'h000E);

        issue(2'b10, 16'd7, 16'd0, 4'd8, 1'b1, 1'b1);
        wait_done();
        chk("div0_result", result, 16'hFFFF);
`ifdef ALU_SEQ_DIVZERO_TRAP_EN
        chk("div0_flag", div_zero, 1);
`else
        chk("div0_flag", div_zero, 0);
`endif

        issue(2'b11, 16'h1234, 16'h8001, 4'd3, 1'b1, 1'b0);
        wait_done();
        chk("pass_result", result, 16'h8001);

        issue(2'b00, 16'h0010, 16'h0020, 4'd4, 1'b0, 1'b0);
        wait_done();

        // start held high through a MUL: the queued ADD is taken only in the DONE cycle
        set_op(2'b01, 16'd9, 16'd9, 4'd10, 1'b1, 1'b1);
        start = 1'b1;
        tick();
        set_op(2'b00, 16'h1234, 16'h0001, 4'd11, 1'b1, 1'b1);
        g = 0;
        while (!in_ready && g < 40) begin
            tick();
            g++;
        end
        chk("hs_mul_done_rv", result_valid, 1);
        chk("hs_mul_done_result", result, 16'd81);
        tick();
        start = 1'b0;
        chk("hs_add_next_cycle", result_valid, 1);
        chk("hs_add_result", result, 16'h1235);
        wait_done();

        issue(2'b01, 16'd3, 16'd5, 4'd12, 1'b1, 1'b1);
        for (int i = 0; i < 3; i++) begin
            tick();
            set_op(2'b00, 16'h0001, 16'h0001, 4'd13, 1'b1, 1'b1);
            start = 1'b1;
            tick();
            start = 1'b0;
        end
        wait_done();
        chk("busy_pulse_result", result, 16'd15);

        issue(2'b01, 16'd1000, 16'd3, 4'd14, 1'b1, 1'b1);
        repeat (4) tick();
        #2 rst_n = 1'b0;
        q.delete();
        #1;
        check_cleared("midop_reset");
        @(posedge clk);
        @(posedge clk);
        #3 rst_n = 1'b1;
        repeat (20) tick();
        chk("post_reset_result_held", result, 0);

        issue(2'b00, 16'd2, 16'd3, 4'd9, 1'b1, 1'b1);
        wait_done();
        chk("post_reset_add", result, 16'd5);

        chk("queue_empty", q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
